mmio_port_responder: RTL and testbench

MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

---
 rtl/mmio_port_responder_if.sv | 24 ++
 rtl/mmio_port_responder.sv | 127 ++++++++++++
 tb/tb_mmio_port_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_responder_if.sv
// Processor MMIO bus and external output-port signals of the port responder.
// master = processor/consumer side, slave = responder.
interface mmio_port_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        PortOutValid;
  logic        PortOutAck;

  modport master (
    output MemWrite, MemRead, Address, WriteData, PortIn, PortOutAck,
    input  ReadData, Hit, PortOut, PortOutValid
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData, PortIn, PortOutAck,
    output ReadData, Hit, PortOut, PortOutValid
  );
endinterface

// File: rtl/mmio_port_responder.sv
// Four-register MMIO window feeding an output FIFO drained through a valid/ack port,
// plus a synchronized 8-bit input with change detection.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  mmio_port_responder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(FIFO_DEPTH);

  typedef enum logic {StIdle, StPresent} state_e;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  state_e           r_state;
  logic [31:0]      r_port_out;
  logic             r_port_valid;
  logic             r_en, r_ovf, r_chg;
  logic [7:0]       r_sync1, r_sync2;

  logic        w_hit, w_empty, w_full, w_pop, w_push;
  logic        w_wr_out, w_wr_ctl, w_clr, w_rd_st, w_chg_set;
  logic [1:0]  w_off;
  logic [31:0] w_status;
  logic        w_unused_addr;

  assign w_hit         = bus.Address[31:4] == BASE_ADDR[31:4];
  assign w_off         = bus.Address[3:2];
  assign w_unused_addr = ^bus.Address[1:0];
  assign w_empty       = r_count == '0;
  assign w_full        = r_count == DepthC;

  // In PRESENT a pop needs the ack; in IDLE the ack is ignored.
  assign w_pop     = r_en && !w_empty && ((r_state == StIdle) || bus.PortOutAck);
  assign w_wr_out  = bus.MemWrite && w_hit && (w_off == 2'd0);
  assign w_wr_ctl  = bus.MemWrite && w_hit && (w_off == 2'd3);
  assign w_push    = w_wr_out && (!w_full || w_pop);
  assign w_clr     = w_wr_ctl && bus.WriteData[1];
  assign w_rd_st   = bus.MemRead && w_hit && (w_off == 2'd2);
  assign w_chg_set = r_sync1 != r_sync2;

  assign w_status = {22'b0, r_port_valid, r_chg, r_ovf, 5'(r_count), w_full, w_empty};

  assign bus.Hit          = w_hit;
  assign bus.PortOut      = r_port_out;
  assign bus.PortOutValid = r_port_valid;

  always_comb begin
    bus.ReadData = '0;
    if (w_hit) begin
      unique case (w_off)
        2'd1:    bus.ReadData = {24'b0, r_sync2};
        2'd2:    bus.ReadData = w_status;
        2'd3:    bus.ReadData = {31'b0, r_en};
        default: bus.ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Output FSM; a CLR does not touch the presented word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_port_out   <= '0;
      r_port_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_port_out   <= r_mem[r_rd_ptr];
            r_port_valid <= 1'b1;
            r_state      <= StPresent;
          end
        end
        StPresent: begin
          if (w_pop) begin
            r_port_out <= r_mem[r_rd_ptr];
          end else if (bus.PortOutAck) begin
            r_port_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_ovf   <= 1'b0;
      r_chg   <= 1'b0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.PortIn;
      r_sync2 <= r_sync1;
      if (w_wr_ctl) r_en <= bus.WriteData[0];
      // Sticky bits: a set beats a same-cycle STATUS-read clear.
      if (w_wr_out && !w_push) r_ovf <= 1'b1;
      else if (w_rd_st)        r_ovf <= 1'b0;
      if (w_chg_set)           r_chg <= 1'b1;
      else if (w_rd_st)        r_chg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench: loads and port deliveries queue expected values; a negedge monitor
// pops and compares whenever the DUT presents a load response or a valid&ack delivery.
module tb_mmio_port_responder;
  localparam logic [31:0] B     = 32'h1001_0040;
  localparam logic [31:0] AOut  = B;
  localparam logic [31:0] AIn   = B + 32'h4;
  localparam logic [31:0] ASt   = B + 32'h8;
  localparam logic [31:0] ACt   = B + 32'hC;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q_rd[$];
  exp_t q_out[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mmio_port_responder_if bus ();

  mmio_port_responder #(
    .BASE_ADDR (B),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.Address   = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic load(input string n, input logic [31:0] a, input logic [31:0] exp);
    q_rd.push_back('{name: n, val: exp});
    bus.MemRead = 1'b1;
    bus.Address = a;
    tick();
    bus.MemRead = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [31:0] v);
    q_out.push_back('{name: n, val: v});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.MemRead) begin
        if (q_rd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_unexpected: got 0x%08h expected no load", bus.ReadData);
        end else begin
          mon_e = q_rd.pop_front();
          check(mon_e.name, bus.ReadData, mon_e.val);
        end
      end
      if (bus.PortOutValid && bus.PortOutAck) begin
        if (q_out.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got 0x%08h expected no delivery", bus.PortOut);
        end else begin
          mon_e = q_out.pop_front();
          check(mon_e.name, bus.PortOut, mon_e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.Address    = '0;
    bus.WriteData  = '0;
    bus.PortIn     = '0;
    bus.PortOutAck = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state and decode
    check("rst_valid", {31'b0, bus.PortOutValid}, 32'h0);
    check("rst_portout", bus.PortOut, 32'h0);
    load("rst_status", ASt, 32'h1);
    load("rst_ctrl", ACt, 32'h0);
    load("rst_in", AIn, 32'h0);
    load("rd_outdata", AOut, 32'h0);
    load("rd_miss", B + 32'h18, 32'h0);
    bus.Address = B + 32'h13;
    #1 check("hit_above", {31'b0, bus.Hit}, 32'h0);
    bus.Address = B - 32'h1;
    #1 check("hit_below", {31'b0, bus.Hit}, 32'h0);
    bus.Address = B + 32'hF;
    #1 check("hit_top", {31'b0, bus.Hit}, 32'h1);

    // Back-to-back drain with Ack held high
    bus.PortOutAck = 1'b1;
    store(AOut, 32'h11);
    store(AOut + 32'h2, 32'h22);
    store(B + 32'h10, 32'h55);
    store(AOut + 32'h1, 32'h33);
    expect_out("seq_0", 32'h11);
    expect_out("seq_1", 32'h22);
    expect_out("seq_2", 32'h33);
    load("cnt3_status", ASt, 32'h0C);
    store(ACt, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_valid", {31'b0, bus.PortOutValid}, 32'h1);
    end
    tick();
    check("seq_idle_valid", {31'b0, bus.PortOutValid}, 32'h0);
    check("seq_hold_last", bus.PortOut, 32'h33);
    load("seq_status", ASt, 32'h1);
    bus.PortOutAck = 1'b0;
    store(ACt, 32'h0);

    // Overflow with EN=0
    for (int i = 0; i < 5; i++) store(AOut, 32'hA1 + 32'(i));
    load("ovf_status", ASt, 32'h92);
    load("ovf_cleared", ASt, 32'h12);

    // Full FIFO: pop and push in the same cycle
    store(ACt, 32'h1);
    expect_out("pp_a1", 32'hA1);
    tick();
    store(AOut, 32'hB1);
    load("pp_full_status", ASt, 32'h212);
    bus.PortOutAck = 1'b1;
    store(AOut, 32'hB2);
    bus.PortOutAck = 1'b0;
    load("pp_status", ASt, 32'h212);
    check("pp_next", bus.PortOut, 32'hA2);

    // CLR keeps the presented word
    store(ACt, 32'h2);
    load("clr_status", ASt, 32'h201);
    check("clr_keep_a2", bus.PortOut, 32'hA2);
    expect_out("clr_a2", 32'hA2);
    bus.PortOutAck = 1'b1;
    tick();
    bus.PortOutAck = 1'b0;
    check("clr_idle", {31'b0, bus.PortOutValid}, 32'h0);
    store(AOut, 32'hDEAD);
    store(AOut, 32'hBEEF);
    store(ACt, 32'h1);
    tick();
    store(ACt, 32'h3);
    repeat (2) tick();
    check("dead_valid", {31'b0, bus.PortOutValid}, 32'h1);
    check("dead_word", bus.PortOut, 32'hDEAD);
    load("dead_status", ASt, 32'h201);
    expect_out("dead_out", 32'hDEAD);
    bus.PortOutAck = 1'b1;
    tick();
    bus.PortOutAck = 1'b0;
    check("dead_idle", {31'b0, bus.PortOutValid}, 32'h0);
    load("dead_empty", ASt, 32'h1);
    store(ACt, 32'h0);

    // Synchronizer latency and CHG
    bus.PortIn = 8'hA5;
    load("in_lat0", AIn, 32'h0);
    load("in_lat1", AIn, 32'h0);
    load("in_sync", AIn, 32'hA5);
    load("chg_set", ASt, 32'h101);
    load("chg_clear", ASt, 32'h1);

    // CHG set coincides with STATUS read clear: set wins
    bus.PortIn = 8'h5A;
    tick();
    load("chg_race_pre", ASt, 32'h1);
    load("chg_race_win", ASt, 32'h101);
    load("chg_race_clr", ASt, 32'h1);

    // Reset while presenting, with concurrent store and ack
    store(AOut, 32'h77);
    store(ACt, 32'h1);
    tick();
    check("pres_valid", {31'b0, bus.PortOutValid}, 32'h1);
    check("pres_word", bus.PortOut, 32'h77);
    reset          = 1'b1;
    bus.MemWrite   = 1'b1;
    bus.Address    = AOut;
    bus.WriteData  = 32'h99;
    bus.PortOutAck = 1'b1;
    tick();
    reset          = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.PortOutAck = 1'b0;
    check("rst2_valid", {31'b0, bus.PortOutValid}, 32'h0);
    check("rst2_portout", bus.PortOut, 32'h0);
    load("rst2_status", ASt, 32'h1);
    load("rst2_nochg", ASt, 32'h1);
    load("rst2_ctrl", ACt, 32'h0);
    load("rst2_in", AIn, 32'h5A);
    load("rst2_chg", ASt, 32'h101);

    tick();
    check("q_out_drained", 32'(q_out.size()), 32'h0);
    check("q_rd_drained", 32'(q_rd.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
